// File: rtl/asfifo_rdpack_pkg.sv
// Shared helpers for the async-FIFO read-side packer: width arithmetic and lane placement.
package asfifo_rdpack_pkg;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    function automatic int out_width(input int in_width, input int ratio);
        return in_width * ratio;
    endfunction

    // Low bit of a lane: lane 0 (first popped) sits in the LS or MS slot.
    function automatic int lane_lo(input int lane, input int ratio, input int in_width,
                                   input int lsb_first);
        return (lsb_first != 0) ? lane * in_width : (ratio - 1 - lane) * in_width;
    endfunction

endpackage

// File: rtl/asfifo_rdpack_outreg.sv
// Output holding register of the packer: one wide word on a stb/ack stream.
module asfifo_rdpack_outreg
    import asfifo_rdpack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              ack,
    output logic              out_free,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_stb
);

    assign out_free = ~out_stb | ack;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_stb   <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load) begin
            out_stb   <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
        end else if (out_stb && ack) begin
            out_stb   <= 1'b0;
        end
    end

endmodule

// File: rtl/asfifo_rdpack.sv
// Drains a show-ahead FIFO read port and packs RATIO narrow words into one wide stb/ack word.
module asfifo_rdpack
    import asfifo_rdpack_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1,
    localparam int OUT_WIDTH = out_width(IN_WIDTH, RATIO),
    localparam int CNT_WIDTH = clog2(RATIO + 1)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_read_en,
    input  logic                 flush,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_stb,
    input  logic                 out_ack
);

    logic [OUT_WIDTH-1:0] acc_p0, acc_nxt;
    logic [CNT_WIDTH-1:0] lane_p0, lane_nxt;
    logic                 flush_pend_p0, flush_pend_nxt;
    logic                 out_free, acc_done, xfer, pop;
    int                   wr_idx;

    assign acc_done = (lane_p0 == CNT_WIDTH'(RATIO)) | (flush_pend_p0 & (lane_p0 != '0));
    assign xfer     = acc_done & out_free;
    // Pop needs room in the accumulator, either a free lane or a word leaving this cycle.
    assign pop      = sys_rst_n & ~fifo_empty & ~flush_pend_p0
                    & ((lane_p0 < CNT_WIDTH'(RATIO)) | xfer);
    assign fifo_read_en = pop;

    always_comb begin
        acc_nxt        = acc_p0;
        lane_nxt       = lane_p0;
        flush_pend_nxt = flush_pend_p0;
        wr_idx         = xfer ? 0 : int'(lane_p0);
        if (xfer) begin
            acc_nxt        = '0;
            lane_nxt       = '0;
            flush_pend_nxt = 1'b0;
        end
        if (pop) begin
            acc_nxt[lane_lo(wr_idx, RATIO, IN_WIDTH, LSB_FIRST) +: IN_WIDTH] = fifo_data;
            lane_nxt = xfer ? CNT_WIDTH'(1) : lane_p0 + CNT_WIDTH'(1);
        end
        // A word leaving without a pop already carries everything the flush asked for.
        if (flush && ((lane_p0 != '0) || pop) && !(xfer && !pop))
            flush_pend_nxt = 1'b1;
    end

    // Stage p0: accumulator, lane counter, pending flush
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_p0        <= '0;
            lane_p0       <= '0;
            flush_pend_p0 <= 1'b0;
        end else begin
            acc_p0        <= acc_nxt;
            lane_p0       <= lane_nxt;
            flush_pend_p0 <= flush_pend_nxt;
        end
    end

    // Stage p1: output holding register
    asfifo_rdpack_outreg #(
        .DATA_W (OUT_WIDTH),
        .CNT_W  (CNT_WIDTH)
    ) u_outreg (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .load       (xfer),
        .load_data  (acc_p0),
        .load_count (lane_p0),
        .ack        (out_ack),
        .out_free   (out_free),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_stb    (out_stb)
    );

endmodule

// File: tb/tb_asfifo_rdpack.sv
// Bench for asfifo_rdpack: LSB-first and MSB-first instances on shared stimulus.
module tb_asfifo_rdpack;

    localparam int IW = 8;
    localparam int R  = 4;
    localparam int OW = IW * R;
    localparam int CW = 3;

    logic          sys_clk, sys_rst_n, fifo_empty, flush, out_ack;
    logic [IW-1:0] fifo_data;
    logic          rd_a, rd_b, stb_a, stb_b;
    logic [OW-1:0] data_a, data_b;
    logic [CW-1:0] cnt_a, cnt_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    asfifo_rdpack #(.IN_WIDTH(IW), .RATIO(R), .LSB_FIRST(1)) u_lsb (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_read_en(rd_a), .flush(flush),
        .out_data(data_a), .out_count(cnt_a), .out_stb(stb_a), .out_ack(out_ack));

    asfifo_rdpack #(.IN_WIDTH(IW), .RATIO(R), .LSB_FIRST(0)) u_msb (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_read_en(rd_b), .flush(flush),
        .out_data(data_b), .out_count(cnt_b), .out_stb(stb_b), .out_ack(out_ack));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    typedef struct {
        logic          empty;
        logic [IW-1:0] data;
        logic          flush;
        logic          ack;
        logic          exp_rd;
        logic          exp_stb;
        logic [OW-1:0] exp_lsb;
        logic [OW-1:0] exp_msb;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic e, input logic [IW-1:0] d, input logic f,
                               input logic a, input logic rd, input logic stb,
                               input logic [OW-1:0] lsb, input logic [OW-1:0] msb,
                               input logic [CW-1:0] cnt);
        vec_t r;
        r = '{e, d, f, a, rd, stb, lsb, msb, cnt};
        return r;
    endfunction

    // Reference model: popped words grouped into output words by count or by flush.
    typedef struct {
        logic [OW-1:0] lsb;
        logic [OW-1:0] msb;
        int            cnt;
    } grp_t;

    logic [IW-1:0] fq[$];
    logic [IW-1:0] cur[$];
    grp_t          grp[$];

    task automatic close_grp();
        grp_t g;
        g.lsb = '0;
        g.msb = '0;
        g.cnt = cur.size();
        for (int i = 0; i < cur.size(); i++) begin
            g.lsb |= OW'(cur[i]) << (IW * i);
            g.msb |= OW'(cur[i]) << (IW * (R - 1 - i));
        end
        grp.push_back(g);
        cur.delete();
    endtask

    task automatic model_step();
        if (fifo_empty) begin
            chk("rnd rd_en while empty lsb", rd_a, 0);
            chk("rnd rd_en while empty msb", rd_b, 0);
        end
        if (stb_a) begin
            if (grp.size() == 0) begin
                chk("rnd unexpected word", stb_a, 0);
            end else begin
                chk("rnd data lsb", data_a, grp[0].lsb);
                chk("rnd data msb", data_b, grp[0].msb);
                chk("rnd count", cnt_a, grp[0].cnt);
                if (out_ack) void'(grp.pop_front());
            end
        end
        if (rd_a && fq.size() > 0) begin
            cur.push_back(fq.pop_front());
            if (cur.size() == R) close_grp();
        end
        if (flush && cur.size() > 0) close_grp();
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        fifo_empty = 1'b0;
        fifo_data  = 8'h5A;
        flush      = 1'b0;
        out_ack    = 1'b0;

        repeat (3) @(negedge sys_clk);
        #1;
        chk("reset rd_en lsb", rd_a, 0);
        chk("reset rd_en msb", rd_b, 0);
        chk("reset stb", stb_a, 0);
        chk("reset data", data_a, 0);
        chk("reset count", cnt_a, 0);
        fifo_empty = 1'b1;
        sys_rst_n  = 1'b1;

        // Post-reset pop, then a one-word flush
        vecs.push_back(v(0, 8'h5A, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(1, 8'h00, 1, 1, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 1, 32'h0000005A, 32'h5A000000, 1));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0));
        // Streaming 0x11..0x88 with ack held high
        vecs.push_back(v(0, 8'h11, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h22, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h33, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h44, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h55, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h66, 0, 1, 1, 1, 32'h44332211, 32'h11223344, 4));
        vecs.push_back(v(0, 8'h77, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h88, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 1, 32'h88776655, 32'h55667788, 4));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0));
        // Backpressure: second word fills, then stall until ack
        vecs.push_back(v(0, 8'h11, 0, 0, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h22, 0, 0, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h33, 0, 0, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h44, 0, 0, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h55, 0, 0, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'h66, 0, 0, 1, 1, 32'h44332211, 32'h11223344, 4));
        vecs.push_back(v(0, 8'h77, 0, 0, 1, 1, 32'h44332211, 32'h11223344, 4));
        vecs.push_back(v(0, 8'h88, 0, 0, 1, 1, 32'h44332211, 32'h11223344, 4));
        vecs.push_back(v(0, 8'h99, 0, 0, 0, 1, 32'h44332211, 32'h11223344, 4));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 1, 32'h44332211, 32'h11223344, 4));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 1, 32'h88776655, 32'h55667788, 4));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0));
        // Flush after two pops; pops held off while pending; flush at lane 0 ignored
        vecs.push_back(v(0, 8'hAA, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'hBB, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(1, 8'h00, 1, 1, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'hCC, 0, 1, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 1, 32'h0000BBAA, 32'hAABB0000, 2));
        vecs.push_back(v(1, 8'h00, 1, 1, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0));
        // Flush coincident with the third pop
        vecs.push_back(v(0, 8'hAA, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'hBB, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'hCC, 1, 1, 1, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(0, 8'hDD, 0, 1, 0, 0, 32'h0, 32'h0, 0));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 1, 32'h00CCBBAA, 32'hAABBCC00, 3));
        vecs.push_back(v(1, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0));

        foreach (vecs[i]) begin
            @(negedge sys_clk);
            fifo_empty = vecs[i].empty;
            fifo_data  = vecs[i].data;
            flush      = vecs[i].flush;
            out_ack    = vecs[i].ack;
            #1;
            chk($sformatf("vec%0d rd_en lsb", i), rd_a, vecs[i].exp_rd);
            chk($sformatf("vec%0d rd_en msb", i), rd_b, vecs[i].exp_rd);
            chk($sformatf("vec%0d stb lsb", i), stb_a, vecs[i].exp_stb);
            chk($sformatf("vec%0d stb msb", i), stb_b, vecs[i].exp_stb);
            if (vecs[i].exp_stb) begin
                chk($sformatf("vec%0d data lsb", i), data_a, vecs[i].exp_lsb);
                chk($sformatf("vec%0d data msb", i), data_b, vecs[i].exp_msb);
                chk($sformatf("vec%0d count", i), cnt_a, vecs[i].exp_cnt);
            end
        end

        // Reset asserted mid-word discards the partial accumulator
        @(negedge sys_clk);
        fifo_empty = 1'b0; fifo_data = 8'hAA; flush = 1'b0; out_ack = 1'b1;
        #1 chk("midrst pop1", rd_a, 1);
        @(negedge sys_clk);
        fifo_data = 8'hBB;
        #1 chk("midrst pop2", rd_a, 1);
        @(negedge sys_clk);
        sys_rst_n = 1'b0; fifo_data = 8'hCC;
        #1;
        chk("midrst rd_en held", rd_a, 0);
        chk("midrst stb", stb_a, 0);
        chk("midrst data", data_a, 0);
        chk("midrst count", cnt_a, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1; fifo_data = 8'h11;
        #1 chk("midrst first pop after release", rd_a, 1);
        @(negedge sys_clk); fifo_data = 8'h22;
        @(negedge sys_clk); fifo_data = 8'h33;
        @(negedge sys_clk); fifo_data = 8'h44;
        @(negedge sys_clk); fifo_empty = 1'b1;
        #1 chk("midrst no stale word", stb_a, 0);
        @(negedge sys_clk);
        #1;
        chk("midrst word stb", stb_a, 1);
        chk("midrst word lsb", data_a, 32'h44332211);
        chk("midrst word msb", data_b, 32'h11223344);
        chk("midrst word count", cnt_a, 4);
        @(negedge sys_clk);
        #1 chk("midrst word consumed", stb_a, 0);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            @(negedge sys_clk);
            while (fq.size() < 6) fq.push_back(8'($urandom));
            fifo_empty = ($urandom_range(0, 3) == 0);
            fifo_data  = fq[0];
            flush      = ($urandom_range(0, 15) == 0);
            out_ack    = ($urandom_range(0, 2) != 0);
            #1;
            model_step();
        end

        for (int c = 0; c < 40; c++) begin
            if (c > 0 && grp.size() == 0 && cur.size() == 0) break;
            @(negedge sys_clk);
            fifo_empty = 1'b1;
            flush      = (c == 0);
            out_ack    = 1'b1;
            #1;
            model_step();
        end
        chk("drain words left", grp.size() + cur.size(), 0);
        repeat (2) @(negedge sys_clk);
        #1 chk("drain no extra word", stb_a, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
